spi_slave_byte: RTL
===================

// Module: spi_slave_byte
// PURPOSE
//   SPI responder (slave) paired with spi_master_byte, for loopback benches and FPGA-side targets.
//   Oversamples sclk/cs_n/mosi/io_update in the clk domain, deserialises MOSI bytes to a FIFO
//   (wrreq) and serialises bytes pulled from a FIFO (rdreq/data_i) onto MISO.
//   SPI mode 1 (CPOL=0, CPHA=1), MSB first, 8-bit frames, any number of bytes per cs_n frame.
// PARAMETERS
//   SYNC_STAGES  2      synchroniser depth for sclk, cs_n, mosi, io_update (>=2)
//   DEFAULT_TX   8'h00  byte shifted out when have_data=0 at a load point
// PORTS
//   clk        in   1  system clock; must be >= 8x sclk frequency
//   rst        in   1  synchronous reset, active-high
//   sclk       in   1  SPI clock from master, idle low, async to clk
//   cs_n       in   1  chip select from master, active-low, async to clk
//   mosi       in   1  serial data from master
//   miso       out  1  serial data to master
//   io_update  in   1  master update strobe, async to clk
//   data_i     in   8  TX byte from FIFO, valid the clk after rdreq (normal-mode FIFO)
//   have_data  in   1  TX FIFO not empty
//   rdreq      out  1  1-clk TX FIFO read pulse
//   data_o     out  8  last complete RX byte
//   wrreq      out  1  1-clk pulse, data_o valid in the same cycle
//   upd_strobe out  1  1-clk pulse per io_update rising edge
//   busy       out  1  synchronised cs_n low
//   underrun   out  1  sticky: DEFAULT_TX sent because have_data=0; cleared only by rst
// BEHAVIOUR
//   Reset (rst=1 at posedge clk): all outputs 0, FSM=IDLE, shift regs/counters 0.
//   Reset mid-frame aborts immediately; the frame is not resumed after rst falls.
//   Inputs pass through SYNC_STAGES flops, then one edge-detect flop; edges act
//   SYNC_STAGES+1 clks after the pin.
//   FSM: IDLE -> LOAD on cs_n fall (sync). LOAD lasts 1 clk -> SHIFT. SHIFT -> LOAD after
//   the 8th sclk rise. cs_n rise in any state -> IDLE.
//   Load point (cs_n fall, or 8th rise): if have_data, rdreq=1 for that clk and
//   tx_reg<=data_i in the following (LOAD) clk. Otherwise no rdreq,
//   tx_reg<=DEFAULT_TX, underrun<=1.
//   TX: on each sclk rise in SHIFT, miso<=tx_reg[7] and tx_reg<=tx_reg<<1; tx bit count 0..7.
//   Master samples miso on the falling edge.
//   RX: on each sclk fall while cs_n low, rx_reg<={rx_reg[6:0],mosi}; after the 8th fall,
//   data_o<=byte and wrreq=1 for 1 clk. The RX counter is independent of the TX FSM.
//   wrreq has no backpressure; the downstream FIFO must accept it.
//   cs_n rise: partial RX byte discarded (no wrreq), both counters cleared, miso<=0,
//   and any pending LOAD is abandoned. A prefetched byte is NOT returned to the FIFO.
//   A sclk edge detected in the same clk as cs_n rise is ignored.
//   rdreq and wrreq may pulse in the same clk.
//   At most one rdreq per byte; no rdreq in IDLE.
//   upd_strobe: rising edge of synced io_update, independent of cs_n.
//   A multi-clk-wide io_update gives exactly one pulse.
//   busy = synced, inverted cs_n.
//   Timing: master must hold cs_n low >= 1 sclk period before the first sclk rise.
// TESTING
//   1 rst=1 for 3 clks with random pins -> miso,rdreq,wrreq,upd_strobe,busy,underrun,data_o = 0.
//   2 sclk=clk/10, one frame, master MOSI 0x3C, have_data=1, data_i=0xAA ->
//     miso bits 1,0,1,0,1,0,1,0; data_o=0x3C with one wrreq; rdreq at cs fall and after 8th rise.
//   3 3-byte frame, MOSI 0x01,0x80,0xFF, data_i toggling 0xAA/0x55 per rdreq ->
//     MISO 0xAA,0x55,0xAA; wrreq x3 with data_o 0x01,0x80,0xFF in order.
//   4 have_data=0, MOSI 0x5A -> MISO 0x00, no rdreq, underrun=1 until rst; data_o=0x5A.
//   5 cs_n raised after 5 sclk -> no wrreq, miso=0, busy=0.
//     Next frame MOSI 0xC3 -> data_o=0xC3 exactly.
//   6 io_update high for 4 clks during a frame -> exactly one upd_strobe;
//     frame data unaffected (0x96 in/out).

Source files
------------

// File: rtl/spi_slave_byte.sv
// SPI mode-1 responder: oversamples the SPI pins in the clk domain, writes each
// received MOSI byte to a downstream FIFO and shifts FIFO-supplied bytes out on MISO.
module spi_slave_byte #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] DEFAULT_TX  = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       cs_n,
   input  logic       mosi,
   output logic       miso,
   input  logic       io_update,
   input  logic [7:0] data_i,
   input  logic       have_data,
   output logic       rdreq,
   output logic [7:0] data_o,
   output logic       wrreq,
   output logic       upd_strobe,
   output logic       busy,
   output logic       underrun
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT
   } state_t;

   state_t     state_q, state_d;

   logic [3:0] pin_raw;
   logic [3:0] pin_s;
   logic [3:0] pin_dly_q;

   logic       sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s, upd_rise;
   logic       load_pt;
   logic       rd_pulse;

   logic [7:0] tx_q, tx_d;
   logic [2:0] tx_cnt_q, tx_cnt_d;
   logic [7:0] rx_q, rx_d;
   logic [2:0] rx_cnt_q, rx_cnt_d;
   logic [7:0] data_q, data_d;
   logic       wrreq_q, wrreq_d;
   logic       miso_q, miso_d;
   logic       und_q, und_d;
   logic       pend_rd_q, pend_rd_d;
   logic       busy_q;
   logic       upd_q;

   assign pin_raw = {io_update, mosi, cs_n, sclk};

   // Chains clear to 0 so a cs_n already low at reset release never looks like a fall.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               chain_q <= '0;
            end else begin
               chain_q <= {chain_q[SYNC_STAGES-2:0], pin_raw[gi]};
            end
         end
         assign pin_s[gi] = chain_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         pin_dly_q <= '0;
      end else begin
         pin_dly_q <= pin_s;
      end
   end

   assign sclk_rise = pin_s[0] & ~pin_dly_q[0];
   assign sclk_fall = ~pin_s[0] & pin_dly_q[0];
   assign cs_rise   = pin_s[1] & ~pin_dly_q[1];
   assign cs_fall   = ~pin_s[1] & pin_dly_q[1];
   assign mosi_s    = pin_s[2];
   assign upd_rise  = pin_s[3] & ~pin_dly_q[3];

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      tx_cnt_d  = tx_cnt_q;
      rx_d      = rx_q;
      rx_cnt_d  = rx_cnt_q;
      data_d    = data_q;
      wrreq_d   = 1'b0;
      miso_d    = miso_q;
      und_d     = und_q;
      pend_rd_d = pend_rd_q;
      load_pt   = 1'b0;
      rd_pulse  = 1'b0;

      if (cs_rise) begin
         // End of frame wins over any sclk edge seen in the same clk.
         state_d   = ST_IDLE;
         tx_d      = '0;
         tx_cnt_d  = '0;
         rx_d      = '0;
         rx_cnt_d  = '0;
         miso_d    = 1'b0;
         pend_rd_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  load_pt = 1'b1;
                  state_d = ST_LOAD;
               end
            end
            ST_LOAD: begin
               tx_d     = pend_rd_q ? data_i : DEFAULT_TX;
               tx_cnt_d = '0;
               state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sclk_rise) begin
                  miso_d   = tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
                  tx_cnt_d = tx_cnt_q + 3'd1;
                  if (tx_cnt_q == 3'd7) begin
                     load_pt = 1'b1;
                     state_d = ST_LOAD;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (load_pt) begin
            rd_pulse  = have_data;
            pend_rd_d = have_data;
            if (!have_data) begin
               und_d = 1'b1;
            end
         end

         // Receive path counts falls on its own, unaffected by the TX load cadence.
         if (state_q != ST_IDLE && sclk_fall) begin
            rx_d     = {rx_q[6:0], mosi_s};
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
               data_d  = {rx_q[6:0], mosi_s};
               wrreq_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         tx_q      <= '0;
         tx_cnt_q  <= '0;
         rx_q      <= '0;
         rx_cnt_q  <= '0;
         data_q    <= '0;
         wrreq_q   <= 1'b0;
         miso_q    <= 1'b0;
         und_q     <= 1'b0;
         pend_rd_q <= 1'b0;
         busy_q    <= 1'b0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_q      <= rx_d;
         rx_cnt_q  <= rx_cnt_d;
         data_q    <= data_d;
         wrreq_q   <= wrreq_d;
         miso_q    <= miso_d;
         und_q     <= und_d;
         pend_rd_q <= pend_rd_d;
         busy_q    <= ~pin_s[1];
         upd_q     <= upd_rise;
      end
   end

   assign miso       = miso_q;
   assign rdreq      = rd_pulse;
   assign data_o     = data_q;
   assign wrreq      = wrreq_q;
   assign upd_strobe = upd_q;
   assign busy       = busy_q;
   assign underrun   = und_q;

endmodule
